// File: rtl/int_gateway_sink.sv
// Receiving end of the interrupt fabric: per-line synchronizers, level-triggered
// gateways (pending/in-flight), aggregated irq and a claim/complete handshake.
module int_gateway_sink #(
    parameter int NUM_INT     = 5,
    parameter int SYNC_STAGES = 2,
    parameter int IDW         = $clog2(NUM_INT + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_INT-1:0] int_in,
    input  logic [NUM_INT-1:0] int_enable,
    output logic               irq,
    input  logic               claim_req,
    output logic               claim_resp_valid,
    output logic [IDW-1:0]     claim_resp_id,
    input  logic               complete_valid,
    input  logic [IDW-1:0]     complete_id,
    output logic               complete_err,
    output logic [NUM_INT-1:0] inflight
);

    logic [NUM_INT-1:0] r_sync [SYNC_STAGES];
    logic [NUM_INT-1:0] r_pend;
    logic [NUM_INT-1:0] r_infl;
    logic               r_resp_valid;
    logic [IDW-1:0]     r_resp_id;
    logic               r_err;

    logic [NUM_INT-1:0] w_s;
    logic [NUM_INT-1:0] w_cand;
    logic [NUM_INT-1:0] w_claim_oh;
    logic [IDW-1:0]     w_claim_id;
    logic [NUM_INT-1:0] w_cmp_hit;
    logic [NUM_INT-1:0] w_cmp_oh;
    logic               w_cmp_ok;
    logic [NUM_INT-1:0] w_set;
    logic [NUM_INT-1:0] w_pend_nxt;
    logic [NUM_INT-1:0] w_infl_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= int_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_cand = r_pend & int_enable;

    // Lowest enabled pending source wins: scan downward so the last hit sticks.
    always_comb begin
        w_claim_oh = '0;
        w_claim_id = '0;
        if (claim_req) begin
            for (int i = NUM_INT - 1; i >= 0; i--) begin
                if (w_cand[i]) begin
                    w_claim_oh    = '0;
                    w_claim_oh[i] = 1'b1;
                    w_claim_id    = IDW'(i + 1);
                end
            end
        end
    end

    always_comb begin
        w_cmp_hit = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            w_cmp_hit[i] = complete_valid && (complete_id == IDW'(i + 1));
        end
    end

    assign w_cmp_oh = w_cmp_hit & r_infl;
    assign w_cmp_ok = |w_cmp_oh;

    // A claim only takes pending bits and a completion only in-flight bits,
    // so the two updates never collide on one source.
    assign w_set      = w_s & ~r_pend & ~r_infl;
    assign w_pend_nxt = (r_pend | w_set) & ~w_claim_oh;
    assign w_infl_nxt = (r_infl | w_claim_oh) & ~w_cmp_oh;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend       <= '0;
            r_infl       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_pend       <= w_pend_nxt;
            r_infl       <= w_infl_nxt;
            r_resp_valid <= claim_req;
            r_err        <= complete_valid & ~w_cmp_ok;
            if (claim_req) begin
                r_resp_id <= w_claim_id;
            end
        end
    end

    assign irq              = |w_cand;
    assign claim_resp_valid = r_resp_valid;
    assign claim_resp_id    = r_resp_id;
    assign complete_err     = r_err;
    assign inflight         = r_infl;

endmodule

// File: tb/tb_int_gateway_sink.sv
// Directed bench for int_gateway_sink: claim responses go through a queue
// scoreboard, everything else is checked inline with immediate assertions.
module tb_int_gateway_sink;

    localparam int NUM_INT = 5;
    localparam int IDW     = 3;

    logic               clock;
    logic               reset;
    logic [NUM_INT-1:0] int_in;
    logic [NUM_INT-1:0] int_enable;
    logic               irq;
    logic               claim_req;
    logic               claim_resp_valid;
    logic [IDW-1:0]     claim_resp_id;
    logic               complete_valid;
    logic [IDW-1:0]     complete_id;
    logic               complete_err;
    logic [NUM_INT-1:0] inflight;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    int_gateway_sink #(
        .NUM_INT    (NUM_INT),
        .SYNC_STAGES(2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .int_in          (int_in),
        .int_enable      (int_enable),
        .irq             (irq),
        .claim_req       (claim_req),
        .claim_resp_valid(claim_resp_valid),
        .claim_resp_id   (claim_resp_id),
        .complete_valid  (complete_valid),
        .complete_id     (complete_id),
        .complete_err    (complete_err),
        .inflight        (inflight)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && claim_resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'(claim_resp_valid), 0);
            end else begin
                chk("claim_id", 32'(claim_resp_id), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic claim(input int exp);
        claim_req = 1'b1;
        exp_q.push_back(exp);
        tick();
        claim_req = 1'b0;
    endtask

    task automatic complete(input int id);
        complete_valid = 1'b1;
        complete_id    = IDW'(id);
        tick();
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    initial begin
        reset          = 1'b1;
        int_in         = '0;
        int_enable     = '1;
        claim_req      = 1'b0;
        complete_valid = 1'b0;
        complete_id    = '0;
        tick(2);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_valid", 32'(claim_resp_valid), 0);
        chk("rst_id", 32'(claim_resp_id), 0);
        chk("rst_err", 32'(complete_err), 0);
        chk("rst_inflight", 32'(inflight), 0);
        reset = 1'b0;

        // latency of a new level through the synchronizer and gateway
        int_in = 'b00100;
        tick();
        chk("lat_e1", 32'(irq), 0);
        tick();
        chk("lat_e2", 32'(irq), 0);
        tick();
        chk("lat_e3", 32'(irq), 1);
        claim(3);
        chk("c3_valid", 32'(claim_resp_valid), 1);
        chk("c3_irq", 32'(irq), 0);
        chk("c3_inflight", 32'(inflight), 'b00100);
        tick();
        chk("c3_pulse", 32'(claim_resp_valid), 0);
        chk("c3_hold", 32'(claim_resp_id), 3);
        int_in = '0;
        tick(3);
        complete(3);
        chk("cmp3_inflight", 32'(inflight), 0);
        chk("cmp3_err", 32'(complete_err), 0);

        // masking affects irq and selection, not latching
        int_in     = 'b10010;
        int_enable = 'b11101;
        tick(3);
        chk("mask_irq", 32'(irq), 1);
        claim(5);
        chk("mask_irq_low", 32'(irq), 0);
        claim(0);
        chk("none_inflight", 32'(inflight), 'b10000);
        int_enable = 'b11111;
        #1;
        chk("unmask_irq", 32'(irq), 1);
        claim(2);
        chk("two_inflight", 32'(inflight), 'b10010);
        int_in = '0;
        tick(3);
        complete(5);
        complete(2);
        chk("two_cleared", 32'(inflight), 0);

        // completion while the line is still asserted
        int_in = 'b00001;
        tick(3);
        claim(1);
        chk("re_inflight", 32'(inflight), 'b00001);
        chk("re_irq_low", 32'(irq), 0);
        complete(1);
        chk("re_cmp_inflight", 32'(inflight), 0);
        chk("re_cmp_irq", 32'(irq), 0);
        tick();
        chk("re_pend_irq", 32'(irq), 1);
        claim(1);
        int_in = '0;
        tick(3);
        complete(1);
        chk("re_clean", 32'(inflight), 0);

        // illegal completions
        complete(0);
        chk("err_id0", 32'(complete_err), 1);
        tick();
        chk("err_pulse", 32'(complete_err), 0);
        complete(6);
        chk("err_id6", 32'(complete_err), 1);
        complete(4);
        chk("err_id4", 32'(complete_err), 1);
        chk("err_inflight", 32'(inflight), 0);
        tick();
        chk("err_pulse2", 32'(complete_err), 0);

        // back-to-back claims
        int_in = 'b01001;
        tick(3);
        claim_req = 1'b1;
        exp_q.push_back(1);
        tick();
        exp_q.push_back(4);
        tick();
        exp_q.push_back(0);
        tick();
        claim_req = 1'b0;
        chk("b2b_inflight", 32'(inflight), 'b01001);
        int_in = '0;
        tick(3);
        complete(1);
        complete(4);
        chk("b2b_clean", 32'(inflight), 0);

        // asynchronous reset mid-operation
        int_in = 'b00110;
        tick(3);
        claim(2);
        claim(3);
        chk("pre_rst_inflight", 32'(inflight), 'b00110);
        int_in = '0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_inflight", 32'(inflight), 0);
        chk("arst_id", 32'(claim_resp_id), 0);
        chk("arst_irq", 32'(irq), 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        complete(2);
        chk("post_rst_err", 32'(complete_err), 1);
        chk("post_rst_inflight", 32'(inflight), 0);
        tick(2);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
